univ_shift_count_reg: RTL and testbench

//  Parametrised universal register built from positive-edge D flip-flops. It extends the single-bit

---
 rtl/univ_reg_pkg.sv | 13 +
 rtl/univ_reg_cell.sv | 41 ++++
 rtl/univ_shift_count_reg.sv | 63 ++++++
 tb/tb_univ_shift_count_reg.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/univ_reg_pkg.sv
// Mode encodings for the universal shift/count register, shared by RTL and benches.
package univ_reg_pkg;
    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'b001;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'b011;
    localparam logic [MODE_W-1:0] MODE_UP   = 3'b100;
    localparam logic [MODE_W-1:0] MODE_DN   = 3'b101;
    localparam logic [MODE_W-1:0] MODE_ROTR = 3'b110;
    localparam logic [MODE_W-1:0] MODE_ROTL = 3'b111;
endpackage

// File: rtl/univ_reg_cell.sv
// One bit of the universal register: 8:1 next-state mux into an async-reset DFF.
// cand[k] is the next value of this bit when mode == k.
module univ_reg_cell
    import univ_reg_pkg::*;
#(
    parameter logic RST_BIT = 1'b0
) (
    input  logic              clock,
    input  logic              reset_b,
    input  logic              en,
    input  logic              clr,
    input  logic [MODE_W-1:0] mode,
    input  logic [7:0]        cand,
    output logic              q
);
    logic nxt;

    // Unknown mode values fall through to hold.
    always_comb begin
        nxt = cand[MODE_HOLD];
        case (mode)
            MODE_SHR:  nxt = cand[MODE_SHR];
            MODE_SHL:  nxt = cand[MODE_SHL];
            MODE_LOAD: nxt = cand[MODE_LOAD];
            MODE_UP:   nxt = cand[MODE_UP];
            MODE_DN:   nxt = cand[MODE_DN];
            MODE_ROTR: nxt = cand[MODE_ROTR];
            MODE_ROTL: nxt = cand[MODE_ROTL];
            default:   nxt = cand[MODE_HOLD];
        endcase
    end

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b)
            q <= RST_BIT;
        else if (clr)
            q <= RST_BIT;
        else if (en)
            q <= nxt;
    end
endmodule

// File: rtl/univ_shift_count_reg.sv
// Universal register: hold/shift/load/count/rotate, WIDTH cells built by generate.
// Define UNIV_REG_SYNC_CLR_EN to add the synchronous clr port.
module univ_shift_count_reg
    import univ_reg_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              clock,
    input  logic              reset_b,
    input  logic              en,
`ifdef UNIV_REG_SYNC_CLR_EN
    input  logic              clr,
`endif
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  d,
    input  logic              si_r,
    input  logic              si_l,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  qb,
    output logic              so_r,
    output logic              so_l,
    output logic              tc
);
    logic                  clr_i;
    logic [WIDTH-1:0]      inc_v, dec_v, shr_v, shl_v, rotr_v, rotl_v;
    logic [WIDTH-1:0][7:0] cand;

`ifdef UNIV_REG_SYNC_CLR_EN
    assign clr_i = clr;
`else
    assign clr_i = 1'b0;
`endif

    assign inc_v  = q + 1'b1;
    assign dec_v  = q - 1'b1;
    assign shr_v  = {si_r, q[WIDTH-1:1]};
    assign shl_v  = {q[WIDTH-2:0], si_l};
    assign rotr_v = {q[0], q[WIDTH-1:1]};
    assign rotl_v = {q[WIDTH-2:0], q[WIDTH-1]};

    // Candidate bit order matches the mode encoding (bit k selected by mode k).
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign cand[i] = {rotl_v[i], rotr_v[i], dec_v[i], inc_v[i],
                          d[i], shl_v[i], shr_v[i], q[i]};

        univ_reg_cell #(.RST_BIT(RESET_VAL[i])) u_cell (
            .clock   (clock),
            .reset_b (reset_b),
            .en      (en),
            .clr     (clr_i),
            .mode    (mode),
            .cand    (cand[i]),
            .q       (q[i])
        );
    end

    assign qb   = ~q;
    assign so_r = q[0];
    assign so_l = q[WIDTH-1];
    // tc flags that the next enabled edge wraps the counter.
    assign tc   = en && (((mode == MODE_UP) && (&q)) || ((mode == MODE_DN) && (q == '0)));
endmodule

// File: tb/tb_univ_shift_count_reg.sv
// Directed bench for univ_shift_count_reg (WIDTH=4, RESET_VAL=0).
// Define UNIV_REG_SYNC_CLR_EN to also exercise the synchronous clear.
module tb_univ_shift_count_reg;
    import univ_reg_pkg::*;

    localparam int W = 4;

    logic              clock = 1'b0;
    logic              reset_b, en, si_r, si_l;
    logic [MODE_W-1:0] mode;
    logic [W-1:0]      d, q, qb;
    logic              so_r, so_l, tc;
`ifdef UNIV_REG_SYNC_CLR_EN
    logic              clr;
`endif

    int checks   = 0;
    int failures = 0;

    univ_shift_count_reg #(.WIDTH(W), .RESET_VAL('0)) dut (
        .clock   (clock),
        .reset_b (reset_b),
        .en      (en),
`ifdef UNIV_REG_SYNC_CLR_EN
        .clr     (clr),
`endif
        .mode    (mode),
        .d       (d),
        .si_r    (si_r),
        .si_l    (si_l),
        .q       (q),
        .qb      (qb),
        .so_r    (so_r),
        .so_l    (so_l),
        .tc      (tc)
    );

    // First rising edge at 20, period 40.
    initial begin
        #20;
        forever begin
            clock = 1'b1; #20;
            clock = 1'b0; #20;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 5 time units after it.
    task automatic step();
        @(posedge clock);
        #5;
    endtask

    initial begin
        #60000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_b = 1'b1; en = 1'b1; mode = MODE_UP;
        d = '0; si_r = 1'b0; si_l = 1'b0;
`ifdef UNIV_REG_SYNC_CLR_EN
        clr = 1'b0;
`endif
        // 1: async reset, release, then count
        #5  reset_b = 1'b0;
        #5  chk("rst_q", q, 4'b0000);
            chk("rst_qb", qb, 4'b1111);
            chk("rst_tc", tc, 1'b0);
        #20 reset_b = 1'b1;
        #5  chk("rel_q", q, 4'b0000);
        step(); chk("cnt1", q, 4'b0001);
        step(); chk("cnt2", q, 4'b0010);

        // 2: load then shift right
        mode = MODE_LOAD; d = 4'b1011;
        step(); chk("load", q, 4'b1011);
        mode = MODE_SHR; si_r = 1'b1;
        step(); chk("shr1", q, 4'b1101);
        si_r = 1'b0;
        step(); chk("shr2", q, 4'b0110);
                chk("so_r", so_r, 1'b0);
                chk("so_l", so_l, 1'b0);

        // 3: wrap up and down
        mode = MODE_LOAD; d = 4'b1111;
        step(); #1 chk("tc_load", tc, 1'b0);
        en = 1'b0; mode = MODE_UP;
        #1 chk("tc_en0", tc, 1'b0);
        en = 1'b1;
        #1 chk("tc_up", tc, 1'b1);
        step(); chk("wrap_up", q, 4'b0000);
                chk("tc_up_after", tc, 1'b0);
        mode = MODE_DN;
        #1 chk("tc_dn", tc, 1'b1);
        step(); chk("wrap_dn", q, 4'b1111);
                chk("tc_dn_after", tc, 1'b0);

        // 4: rotate left
        mode = MODE_LOAD; d = 4'b1001;
        step();
        mode = MODE_ROTL;
        step(); chk("rotl1", q, 4'b0011);
        step(); chk("rotl2", q, 4'b0110);
        step(); chk("rotl3", q, 4'b1100);
        step(); chk("rotl4", q, 4'b1001);
                chk("rotl_qb", qb, 4'b0110);

        // rotate right, shift left, hold
        mode = MODE_ROTR;
        step(); chk("rotr", q, 4'b1100);
        mode = MODE_SHL; si_l = 1'b1;
        step(); chk("shl", q, 4'b1001);
                chk("so_l_shl", so_l, 1'b1);
        mode = MODE_HOLD;
        step(); chk("hold", q, 4'b1001);

        // 5: reset between edges acts immediately; en=0 blocks load
        mode = MODE_LOAD; d = 4'b0110;
        step();
        mode = MODE_UP;
        step(); chk("pre_rst", q, 4'b0111);
        #3 reset_b = 1'b0;
        #1 chk("mid_rst", q, 4'b0000);
        #10 reset_b = 1'b1;
        en = 1'b0; mode = MODE_LOAD; d = 4'b1111;
        step(); chk("en0_hold", q, 4'b0000);
        en = 1'b1;
        step(); chk("en1_load", q, 4'b1111);

`ifdef UNIV_REG_SYNC_CLR_EN
        // 6: synchronous clear beats load
        d = 4'b0101;
        step(); chk("pre_clr", q, 4'b0101);
        clr = 1'b1; d = 4'b1111;
        step(); chk("clr", q, 4'b0000);
        clr = 1'b0;
        step(); chk("post_clr", q, 4'b1111);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
